keypad_scan_ctrl: RTL and testbench
===================================

// Module: keypad_scan_ctrl
// PURPOSE
//   Scan controller for the 4x4 matrix keypad. Drives active-low one-hot columns at a slow dwell rate and samples the active-low rows.
//   Debounces whole-matrix frames and keeps a stable 16-bit key level vector.
//   Turns press/release edges into 5-bit events in a small FIFO with a valid/ready handshake. Sits between keypad pins and game/menu logic.
// PARAMETERS
//   CLK_DIV     50000  clk cycles each column is driven before its rows are sampled (>=8)
//   DB_SCANS    4      consecutive identical frames required to accept a new key level (>=1)
//   FIFO_DEPTH  4      event FIFO entries (power of 2, >=2)
// PORTS
//   clk        in   1   system clock, all logic on rising edge
//   rst_n      in   1   asynchronous, active-low reset
//   enable     in   1   1 = scanning runs; 0 = paused
//   key_col    out  4   column drive, active-low one-hot; 4'b1111 = idle
//   key_row    in   4   row sense, active-low (0 = pressed)
//   key_state  out  16  debounced level, bit i = key i held
//   frame_tick out  1   1-cycle pulse when a full 4-column frame has been sampled
//   ev_valid   out  1   FIFO non-empty
//   ev_ready   in   1   consumer pop; pop occurs when ev_valid & ev_ready
//   ev_code    out  5   FIFO head {release, key_idx[3:0]}
//   ev_ovf     out  1   sticky: an event was dropped because the FIFO was full
//   ovf_clr    in   1   synchronous clear of ev_ovf (wins over a same-cycle set)
// BEHAVIOUR
//   Reset values: key_col=4'b1110, col=0, dwell=0, key_state=0, frame_tick=0, FIFO empty (ev_valid=0), ev_code=0, ev_ovf=0, stable_cnt=0, pending=0.
//   Column scan:
//   - dwell counts 0..CLK_DIV-1 while enable=1.
//   - At dwell==CLK_DIV-1 (the sample edge), ~key_row is captured for column c. dwell wraps to 0, c advances 0->1->2->3->0.
//   - key_col = ~(4'b0001<<c) from the next cycle.
//   Key index mapping: row bit r, column c -> key_idx = (3-r)*4 + c.
//   Frame completion (the sample edge of column 3):
//   - frame_tick is high the following cycle.
//   - If the new raw frame equals the previous raw frame, stable_cnt increments, saturating at DB_SCANS-1; otherwise stable_cnt is cleared to 0.
//   Level accept (stable_cnt==DB_SCANS-1 at frame completion and raw != key_state):
//   - At the next edge, key_state <= raw.
//   - pending_press |= raw & ~key_state.
//   - pending_rel |= ~raw & key_state.
//   - With DB_SCANS=1, every frame is accepted.
//   Event drain: one event per cycle while pending != 0.
//   - Presses are drained before releases; lowest key_idx first.
//   - The selected pending bit is cleared whether or not the event is stored.
//   - CLK_DIV>=8 guarantees a drain finishes before the next frame.
//   Latency: sample edge E completes the frame -> key_state at E+1 -> first push at E+2 -> ev_valid=1 after E+2.
//   FIFO:
//   - Push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
//   - Otherwise the event is dropped and ev_ovf is set.
//   - Pop on empty is ignored. Order is FIFO. ev_code holds its value until popped.
//   enable=0:
//   - key_col=4'b1111; dwell, col and stable_cnt clear to 0; the partial frame is discarded.
//   - key_state, the FIFO and the pending drain continue unaffected.
//   - On enable=1, the scan restarts at column 0 with key_col=4'b1110.
//   Async rst_n low mid-frame or mid-drain: everything returns to the reset values immediately; no event survives.
// STRUCTURE
//   keypad_pkg:
//   - Constants KEY_N=16, COL_N=4, ROW_N=4, COL_IDLE=4'b1111.
//   - typedef key_evt_t {logic rel; logic [3:0] idx;}.
//   - Function key_idx(row, col) implementing the index mapping.
//   Sub-module keypad_evt_fifo: synchronous FIFO, parameter FIFO_DEPTH, width $bits(key_evt_t), full/empty/count outputs.
//   Top level: dwell/column counter, frame/debounce registers, pending masks with priority encoder.
// TESTING (CLK_DIV=8, DB_SCANS=2, FIFO_DEPTH=4)
//   1. Reset, enable=1, no keys.
//      -> key_col cycles 1110,1101,1011,0111 (8 cycles each); frame_tick every 32 cycles; ev_valid=0.
//   2. Pull key_row[3] low only while col0 is driven, for 3 frames, ev_ready=1.
//      -> key_state=16'h0001; one event 5'b0_0000.
//      Then release.
//      -> event 5'b1_0000; key_state=0.
//   3. Toggle the row on alternate frames (bounce).
//      -> stable_cnt never reaches 1; key_state stays 0; no events.
//   4. Press keys 0,5,9,15,3,6 together with ev_ready=0.
//      -> events 0,3,5,6 in the FIFO; 9 and 15 dropped; ev_ovf=1.
//      Pulse ovf_clr.
//      -> ev_ovf=0.
//   5. With the FIFO full, hold ev_ready=1 while a new event is pushed.
//      -> push and pop happen in the same cycle; count stays 4; no overflow.
//   6. Deassert enable mid-column-2 and assert rst_n=0 during a drain.
//      -> key_col=1111 while paused; on reset, FIFO empty, key_state=0, key_col=1110.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared constants, event payload type and key index mapping for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned KEY_N = 16;
  localparam int unsigned COL_N = 4;
  localparam int unsigned ROW_N = 4;
  localparam logic [3:0]  COL_IDLE = 4'b1111;

  typedef struct packed {
    logic       rel;
    logic [3:0] idx;
  } key_evt_t;

  // Row r, column c -> (3-r)*4 + c; for 2-bit fields that is {3-r, c}.
  function automatic logic [3:0] key_idx(input logic [1:0] row, input logic [1:0] col);
    return {2'(2'd3 - row), col};
  endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// Shift-register event FIFO: the head always sits in entry 0 so the output is a flop.
module keypad_evt_fifo
  import keypad_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  key_evt_t      din,
  input  logic          pop,
  output key_evt_t      dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  key_evt_t         mem [FIFO_DEPTH];
  logic             pop_ok;
  logic             push_ok;
  logic [AW-1:0]    wr_idx;

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign wr_idx  = pop_ok ? AW'(count - CW'(1)) : AW'(count);
  assign dout    = mem[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (pop_ok) begin
        for (int unsigned i = 0; i + 1 < FIFO_DEPTH; i++) mem[i] <= mem[i+1];
      end
      // A same-cycle push lands after the shift, so it overrides the shifted slot.
      if (push_ok) mem[wr_idx] <= din;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: column drive, frame debounce, press/release event generation into a FIFO.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 50000,
  parameter int unsigned DB_SCANS   = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  output logic [COL_N-1:0] key_col,
  input  logic [ROW_N-1:0] key_row,
  output logic [KEY_N-1:0] key_state,
  output logic             frame_tick,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [4:0]       ev_code,
  output logic             ev_ovf,
  input  logic             ovf_clr
);

  localparam int unsigned DW = $clog2(CLK_DIV);
  localparam int unsigned SW = (DB_SCANS > 1) ? $clog2(DB_SCANS) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [DW-1:0]    dwell;
  logic [1:0]       col;
  logic [KEY_N-1:0] raw_acc;
  logic [KEY_N-1:0] prev_raw;
  logic [SW-1:0]    stable_cnt;
  logic [KEY_N-1:0] pend_press;
  logic [KEY_N-1:0] pend_rel;

  logic             sample_c;
  logic             frame_end_c;
  logic [1:0]       next_col_c;
  logic [KEY_N-1:0] frame_c;
  logic             accept_c;
  logic             sel_rel_c;
  logic [KEY_N-1:0] sel_mask_c;
  logic [3:0]       sel_idx_c;
  logic [KEY_N-1:0] clr_press_c;
  logic [KEY_N-1:0] clr_rel_c;
  logic             push_c;
  logic             pop_c;
  logic             drop_c;
  key_evt_t         evt_c;
  key_evt_t         fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;

  assign sample_c    = enable && (dwell == DW'(CLK_DIV - 1));
  assign frame_end_c = sample_c && (col == 2'd3);
  assign next_col_c  = sample_c ? col + 2'd1 : col;

  // Current partial frame with the column being sampled merged in.
  always_comb begin
    frame_c = raw_acc;
    for (int unsigned r = 0; r < ROW_N; r++) frame_c[key_idx(2'(r), col)] = ~key_row[r];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell      <= '0;
      col        <= '0;
      key_col    <= 4'b1110;
      raw_acc    <= '0;
      prev_raw   <= '0;
      stable_cnt <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end_c;
      if (!enable) begin
        dwell      <= '0;
        col        <= '0;
        stable_cnt <= '0;
        key_col    <= COL_IDLE;
      end else begin
        key_col <= ~(4'b0001 << next_col_c);
        if (sample_c) begin
          dwell   <= '0;
          col     <= next_col_c;
          raw_acc <= frame_c;
          if (col == 2'd3) begin
            prev_raw <= frame_c;
            if (frame_c != prev_raw)                  stable_cnt <= '0;
            else if (stable_cnt != SW'(DB_SCANS - 1)) stable_cnt <= stable_cnt + SW'(1);
          end
        end else begin
          dwell <= dwell + DW'(1);
        end
      end
    end
  end

  // The cycle after a completed frame decides whether the debounced level moves.
  assign accept_c = frame_tick && (stable_cnt == SW'(DB_SCANS - 1)) && (prev_raw != key_state);

  // Priority pick: any press before any release, lowest key index first.
  always_comb begin
    sel_rel_c  = ~|pend_press;
    sel_mask_c = sel_rel_c ? pend_rel : pend_press;
    push_c     = |sel_mask_c;
    sel_idx_c  = '0;
    for (int i = int'(KEY_N) - 1; i >= 0; i--) begin
      if (sel_mask_c[i]) sel_idx_c = 4'(i);
    end
    clr_press_c = sel_rel_c ? '0 : (KEY_N'(1) << sel_idx_c);
    clr_rel_c   = sel_rel_c ? (KEY_N'(1) << sel_idx_c) : '0;
    evt_c.rel   = sel_rel_c;
    evt_c.idx   = sel_idx_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_state  <= '0;
      pend_press <= '0;
      pend_rel   <= '0;
      ev_ovf     <= 1'b0;
    end else begin
      pend_press <= (pend_press & ~clr_press_c) | (accept_c ? (prev_raw & ~key_state) : '0);
      pend_rel   <= (pend_rel & ~clr_rel_c) | (accept_c ? (~prev_raw & key_state) : '0);
      if (accept_c) key_state <= prev_raw;
      if (ovf_clr)     ev_ovf <= 1'b0;
      else if (drop_c) ev_ovf <= 1'b1;
    end
  end

  assign pop_c  = ev_ready && (fifo_count != '0);
  assign drop_c = push_c && fifo_full && !pop_c;

  keypad_evt_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_c),
    .din   (evt_c),
    .pop   (pop_c),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign ev_valid = ~fifo_empty;
  assign ev_code  = fifo_dout;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Randomized and directed bench for keypad_scan_ctrl against a frame/queue level reference model.
module tb_keypad_scan_ctrl;

  localparam int unsigned CLK_DIV    = 8;
  localparam int unsigned DB_SCANS   = 2;
  localparam int unsigned FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic [3:0]  key_col;
  logic [3:0]  key_row;
  logic [15:0] key_state;
  logic        frame_tick;
  logic        ev_valid;
  logic        ev_ready = 1'b0;
  logic [4:0]  ev_code;
  logic        ev_ovf;
  logic        ovf_clr = 1'b0;

  keypad_scan_ctrl #(.CLK_DIV(CLK_DIV), .DB_SCANS(DB_SCANS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .key_col    (key_col),
    .key_row    (key_row),
    .key_state  (key_state),
    .frame_tick (frame_tick),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_code    (ev_code),
    .ev_ovf     (ev_ovf),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  // Physical keypad: a row reads low when a pressed key sits on a driven column.
  logic [15:0] pressed = '0;
  always_comb begin
    key_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!key_col[c] && pressed[(3 - r) * 4 + c]) key_row[r] = 1'b0;
  end

  int          vectors = 0;
  int          miscompares = 0;

  int          n;
  logic [3:0]  m_col;
  logic [3:0]  one = 4'b0001;
  logic [15:0] m_state, last_frame, acc_frame;
  int          stable;
  bit          m_tick, accept_pend, m_ovf, frame_done;
  logic [4:0]  q[$];
  logic [4:0]  drain[$];

  logic [15:0] want_pressed = '0;
  bit          want_en = 1'b1, want_rst = 1'b0, want_clr = 1'b0, clr_rand = 1'b0;
  int          rdy_mode = 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    n = 0; m_col = 4'b1110; m_state = '0; last_frame = '0; acc_frame = '0;
    stable = 0; m_tick = 0; accept_pend = 0; m_ovf = 0; frame_done = 0;
    q.delete(); drain.delete();
  endtask

  task automatic check_outputs();
    chk("key_col", 32'(key_col), 32'(m_col));
    chk("key_state", 32'(key_state), 32'(m_state));
    chk("frame_tick", 32'(frame_tick), 32'(m_tick));
    chk("ev_valid", 32'(ev_valid), 32'(q.size() > 0));
    if (q.size() > 0) chk("ev_code", 32'(ev_code), 32'(q[0]));
    chk("ev_ovf", 32'(ev_ovf), 32'(m_ovf));
  endtask

  // Effect of the coming rising edge given the inputs now applied.
  task automatic advance();
    bit pop, drop;
    logic [4:0] code;
    logic [15:0] frame;
    if (!rst_n) begin
      model_reset();
      return;
    end
    drop = 0;
    pop = ev_ready && q.size() > 0;
    if (pop) void'(q.pop_front());
    if (drain.size() > 0) begin
      code = drain.pop_front();
      if (q.size() < FIFO_DEPTH) q.push_back(code);
      else drop = 1;
    end
    if (ovf_clr) m_ovf = 0;
    else if (drop) m_ovf = 1;
    if (accept_pend) begin
      for (int i = 0; i < 16; i++) if (acc_frame[i] && !m_state[i]) drain.push_back({1'b0, 4'(i)});
      for (int i = 0; i < 16; i++) if (!acc_frame[i] && m_state[i]) drain.push_back({1'b1, 4'(i)});
      m_state = acc_frame;
      accept_pend = 0;
    end
    m_tick = 0;
    if (enable) begin
      n++;
      m_col = ~(one << ((n / CLK_DIV) % 4));
      if (n % (4 * CLK_DIV) == 0) begin
        frame = pressed;
        if (frame == last_frame) begin
          if (stable < DB_SCANS - 1) stable++;
        end else begin
          stable = 0;
        end
        last_frame = frame;
        m_tick = 1;
        frame_done = 1;
        if (stable == DB_SCANS - 1) begin
          accept_pend = 1;
          acc_frame = frame;
        end
      end
    end else begin
      n = 0;
      stable = 0;
      m_col = 4'hF;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    if (frame_done || n == 0) pressed = want_pressed;
    frame_done = 0;
    case (rdy_mode)
      0:       ev_ready = 1'b0;
      1:       ev_ready = 1'b1;
      2:       ev_ready = 1'($urandom_range(0, 1));
      default: ev_ready = (drain.size() > 0);
    endcase
    ovf_clr = want_clr || (clr_rand && $urandom_range(0, 19) == 0);
    enable  = want_en;
    rst_n   = want_rst;
    advance();
  endtask

  task automatic run_frames(input int k);
    int got = 0;
    int guard = 0;
    while (got < k && guard < 64 * CLK_DIV * k) begin
      step();
      if (m_tick) got++;
      guard++;
    end
    if (got < k) chk("frame_timeout", 32'(got), 32'(k));
  endtask

  initial begin
    int guard;
    model_reset();
    repeat (3) step();
    chk("rst_ev_code", 32'(ev_code), 32'd0);
    chk("rst_key_col", 32'(key_col), 32'hE);
    want_rst = 1'b1;

    // Idle scan.
    run_frames(3);

    // Single key press then release.
    want_pressed = 16'h0001;
    run_frames(3);
    chk("t2_press_state", 32'(key_state), 32'h0001);
    want_pressed = 16'h0000;
    run_frames(3);
    chk("t2_release_state", 32'(key_state), 32'h0000);

    // Bounce: alternating frames never debounce.
    for (int i = 0; i < 6; i++) begin
      want_pressed = (i % 2 == 0) ? 16'h0001 : 16'h0000;
      run_frames(1);
    end
    chk("t3_bounce_state", 32'(key_state), 32'h0000);
    chk("t3_bounce_valid", 32'(ev_valid), 32'd0);

    // Overflow with consumer stalled.
    rdy_mode = 0;
    want_pressed = 16'h8269;
    run_frames(3);
    repeat (10) step();
    chk("t4_state", 32'(key_state), 32'h8269);
    chk("t4_ovf", 32'(ev_ovf), 32'd1);
    chk("t4_head", 32'(ev_code), 32'h00);
    want_clr = 1'b1;
    step();
    want_clr = 1'b0;
    step();
    chk("t4_ovf_clr", 32'(ev_ovf), 32'd0);

    // Full FIFO with a pop in every push cycle: no drops.
    rdy_mode = 3;
    want_pressed = 16'h0000;
    run_frames(3);
    repeat (10) step();
    chk("t5_ovf", 32'(ev_ovf), 32'd0);
    chk("t5_valid", 32'(ev_valid), 32'd1);
    rdy_mode = 1;
    repeat (6) step();

    // Random key traffic with a random consumer.
    rdy_mode = 2;
    clr_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) want_pressed = 16'($urandom & $urandom & $urandom);
      run_frames(1);
    end
    clr_rand = 1'b0;
    rdy_mode = 1;
    run_frames(2);

    // Pause in the middle of column 2, then resume.
    want_pressed = 16'h0010;
    guard = 0;
    while (!((n / CLK_DIV) % 4 == 2 && n % CLK_DIV == 3) && guard < 200) begin
      step();
      guard++;
    end
    chk("t6_reach_col2", 32'(guard < 200), 32'd1);
    want_en = 1'b0;
    repeat (12) step();
    chk("t6_pause_col", 32'(key_col), 32'hF);
    want_en = 1'b1;
    repeat (2) step();
    chk("t6_resume_col", 32'(key_col), 32'hE);
    run_frames(3);
    chk("t6_resume_state", 32'(key_state), 32'h0010);

    // Async reset in the middle of a drain.
    rdy_mode = 0;
    want_pressed = 16'hF0F0;
    run_frames(2);
    guard = 0;
    while (!(q.size() > 0 && drain.size() > 0) && guard < 100) begin
      step();
      guard++;
    end
    chk("t6_mid_drain", 32'(guard < 100), 32'd1);
    #2;
    rst_n = 1'b0;
    want_rst = 1'b0;
    model_reset();
    #1;
    check_outputs();
    chk("t6_rst_valid", 32'(ev_valid), 32'd0);
    chk("t6_rst_state", 32'(key_state), 32'd0);
    chk("t6_rst_col", 32'(key_col), 32'hE);
    repeat (3) step();
    want_rst = 1'b1;
    want_pressed = 16'h0000;
    rdy_mode = 1;
    run_frames(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
